fftsink: RTL and testbench
==========================

# fftsink

Output-side consumer for the pipelined FFT core. It takes the core's free-running result stream (clock enable, result word, sync) and aligns it to frame boundaries using sync. Each bin is tagged with its index and an end-of-frame marker, and the tagged words are buffered in a small FIFO. The FIFO is presented as a valid/ready stream to downstream logic. The FFT cannot be stalled, so on backpressure this block drops whole frames and flags the loss.

## Interface
- OWIDTH, 22: bits per real/imag component of a result word
- LGWIDTH, 11: log2 FFT size; bin counter width
- LGFIFO, 4: log2 FIFO depth in entries
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_ce  in  1  result-word strobe from FFT core
- i_result  in  2*OWIDTH  FFT result, real in high half, imag in low half
- i_sync  in  1  high with the i_ce carrying bin 0 of a frame
- i_ready  in  1  downstream accepts the current word
- i_clr  in  1  clears sticky flags o_overflow and o_sync_err
- o_valid  out  1  FIFO head holds a word
- o_data  out  2*OWIDTH  head result word
- o_bin  out  LGWIDTH  bin index of head word
- o_last  out  1  head word is bin 2^LGWIDTH-1
- o_aligned  out  1  state is RUN
- o_overflow  out  1  sticky; a frame was dropped
- o_sync_err  out  1  sticky; i_sync seen at a nonzero expected bin

## Operation
- Reset (async, i_reset_n low): state IDLE, bin counter 0, FIFO pointers and count 0, o_valid 0, o_aligned 0, o_overflow 0, o_sync_err 0. o_data, o_bin and o_last are don't-care while o_valid is 0.
- States:
  - IDLE: discard all i_ce words until i_ce&&i_sync.
  - RUN: write each i_ce word.
  - DROP: discard words until the next frame start.
- Frame start (any state, i_ce&&i_sync):
  - If FIFO not full: write the word as bin 0, counter←1, state←RUN.
  - If FIFO full: state←DROP, o_overflow←1.
- In RUN, an i_ce without sync:
  - Write {last=(cnt==2^LGWIDTH-1), bin=cnt, data}.
  - cnt←cnt+1, wrapping mod 2^LGWIDTH.
- In RUN, i_ce&&i_sync with cnt≠0: o_sync_err←1, then handle as a frame start (realignment). An i_sync arriving at cnt==0 is the expected case and sets no error.
- Overflow in RUN: i_ce with FIFO full → word discarded, o_overflow←1, state←DROP. The partial frame already in the FIFO stays. It carries no o_last; downstream detects truncation from the next o_bin==0.
- Full is count==2^LGFIFO using the registered count. A pop in the same cycle does not free space for that cycle's write (conservative rule).
- Pop: o_valid&&i_ready advances the read pointer.
- Simultaneous push and pop: count is unchanged.
- i_ready while !o_valid is ignored.
- i_clr clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- i_ce low: no state, counter or write change. Pops still proceed.

## Timing
- Write latency: a word captured at edge N appears at the FIFO head with o_valid high after edge N (usable in cycle N+1) when the FIFO was empty.
- o_data, o_bin and o_last come combinationally from the head register entry; there is no extra register stage.
- Throughput is one word per clock in and one out.
- o_aligned reflects the state after each edge.
- Sticky flags update on the same edge as the triggering event.

## Structure
- Package fftsink_pkg holds:
  - the state enum (IDLE, RUN, DROP)
  - localparam entry width = 2*OWIDTH+LGWIDTH+1
  - field offsets of the packed {last,bin,data} entry
- Sub-module fftsink_fifo is a synchronous register-array FIFO with push/pop, full/empty and first-word fall-through head. The top level is the framing FSM, bin counter and flags.

## Test plan
All scenarios use LGWIDTH=4 and LGFIFO=2 unless stated otherwise.
- Align: 5 i_ce words without sync, then sync with data 0x1 continuing for 16 words, i_ready=1 → exactly 16 outputs, o_bin 0..15, o_last only on bin 15, o_aligned high from the sync edge, no flags set.
- Backpressure overflow: i_ready=0 through a frame → 4 words (bins 0–3) held, o_overflow=1, state DROP. Raise i_ready and send the next sync frame → bins 0–3 drain without o_last, then a full bins 0–15 frame follows.
- Sync error: sync at bin 0, then a second sync at expected bin 7 → o_sync_err=1 and the word is emitted as bin 0. i_clr pulse then clears it.
- Gapped i_ce: i_ce toggling 1/0 across a frame → bin indices contiguous, no duplicates, o_last at bin 15.
- Full with concurrent pop: FIFO full, i_ready=1 and i_ce word in the same cycle → word dropped, o_overflow=1, count 3 after the edge.
- Async reset mid-frame: drop i_reset_n between edges at bin 9 with 2 entries queued → o_valid=0, o_aligned=0, flags 0 immediately, without waiting for a clock edge. After release, non-sync words are ignored.

Source files
------------

// File: rtl/fftsink_pkg.sv
// fftsink_pkg: shared types and entry layout for the FFT output sink.
// The FIFO entry is packed as {last, bin, data}: data occupies the low
// 2*OWIDTH bits, bin sits directly above it, and last is the MSB.
package fftsink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int unsigned OWIDTH_DFLT  = 22;
  localparam int unsigned LGWIDTH_DFLT = 11;
  localparam int unsigned LGFIFO_DFLT  = 4;

  localparam int unsigned ENTRY_W_DFLT = 2*OWIDTH_DFLT + LGWIDTH_DFLT + 1;
  localparam int unsigned DATA_LSB     = 0;

  // Layout helpers so non-default parameterisations share one definition.
  function automatic int unsigned entry_w(input int unsigned ow, input int unsigned lgw);
    return 2*ow + lgw + 1;
  endfunction

  function automatic int unsigned bin_lsb(input int unsigned ow);
    return 2*ow;
  endfunction

  function automatic int unsigned last_bit(input int unsigned ow, input int unsigned lgw);
    return 2*ow + lgw;
  endfunction

endpackage

// File: rtl/fftsink_fifo.sv
// fftsink_fifo: register-array FIFO with first-word fall-through head.
// Ports:
//   i_clk, i_reset_n      clock, async active-low reset
//   i_push, i_data        write request and entry (ignored when full)
//   i_pop                 read request (ignored when empty)
//   o_head                entry at the read pointer, valid when !o_empty
//   o_full, o_empty       occupancy from the registered count
module fftsink_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LGDEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned DEPTH = 1 << LGDEPTH;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGDEPTH:0]   count_q, count_d;
  logic               do_push_c, do_pop_c;

  assign o_full  = (count_q == (LGDEPTH+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_comb begin
    do_push_c = i_push & ~o_full;
    do_pop_c  = i_pop & ~o_empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + LGDEPTH'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + LGDEPTH'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + (LGDEPTH+1)'(1);
      2'b01:   count_d = count_q - (LGDEPTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are qualified by the count.
  always_ff @(posedge i_clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/fftsink.sv
// fftsink: frames the free-running FFT result stream on i_sync, tags each
// bin with its index and an end-of-frame flag, and buffers it for a
// valid/ready consumer. Whole frames are dropped on backpressure.
// Ports:
//   i_clk, i_reset_n         clock, async active-low reset
//   i_ce, i_result, i_sync   FFT result strobe, word {re,im}, bin-0 marker
//   i_ready                  downstream accepts head word
//   i_clr                    clears o_overflow and o_sync_err
//   o_valid, o_data, o_bin, o_last   FIFO head stream
//   o_aligned                framing state is RUN
//   o_overflow, o_sync_err   sticky loss / misaligned-sync flags
module fftsink
  import fftsink_pkg::*;
#(
  parameter int unsigned OWIDTH  = OWIDTH_DFLT,
  parameter int unsigned LGWIDTH = LGWIDTH_DFLT,
  parameter int unsigned LGFIFO  = LGFIFO_DFLT
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ce,
  input  logic [2*OWIDTH-1:0]   i_result,
  input  logic                  i_sync,
  input  logic                  i_ready,
  input  logic                  i_clr,
  output logic                  o_valid,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic [LGWIDTH-1:0]    o_bin,
  output logic                  o_last,
  output logic                  o_aligned,
  output logic                  o_overflow,
  output logic                  o_sync_err
);

  localparam int unsigned DW  = 2*OWIDTH;
  localparam int unsigned EW  = entry_w(OWIDTH, LGWIDTH);
  localparam int unsigned BL  = bin_lsb(OWIDTH);
  localparam int unsigned LB  = last_bit(OWIDTH, LGWIDTH);
  localparam logic [LGWIDTH-1:0] BIN_MAX = '1;

  state_e             state_q, state_d;
  logic [LGWIDTH-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               serr_q, serr_d;
  logic               aligned_q, aligned_d;

  logic               push_c, pop_c, full_c, empty_c;
  logic               ovf_set_c, serr_set_c;
  logic [LGWIDTH-1:0] wr_bin_c;
  logic [EW-1:0]      wr_entry_c, head_c;

  // Framing FSM, bin counter and sticky flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    push_c     = 1'b0;
    wr_bin_c   = cnt_q;
    ovf_set_c  = 1'b0;
    serr_set_c = 1'b0;
    if (i_ce) begin
      if (i_sync) begin
        // Sync mid-frame means the core and our counter disagree; realign.
        if (state_q == ST_RUN && cnt_q != '0) serr_set_c = 1'b1;
        if (!full_c) begin
          push_c   = 1'b1;
          wr_bin_c = '0;
          cnt_d    = LGWIDTH'(1);
          state_d  = ST_RUN;
        end else begin
          ovf_set_c = 1'b1;
          state_d   = ST_DROP;
        end
      end else if (state_q == ST_RUN) begin
        if (!full_c) begin
          push_c = 1'b1;
          cnt_d  = cnt_q + LGWIDTH'(1);
        end else begin
          ovf_set_c = 1'b1;
          state_d   = ST_DROP;
        end
      end
    end
    // Set takes priority over a coincident clear.
    ovf_d     = ovf_set_c | (ovf_q & ~i_clr);
    serr_d    = serr_set_c | (serr_q & ~i_clr);
    aligned_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      serr_q    <= serr_d;
      aligned_q <= aligned_d;
    end
  end

  assign wr_entry_c = {(wr_bin_c == BIN_MAX), wr_bin_c, i_result};
  assign pop_c      = i_ready & ~empty_c;

  fftsink_fifo #(
    .WIDTH   (EW),
    .LGDEPTH (LGFIFO)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_c),
    .i_data    (wr_entry_c),
    .i_pop     (pop_c),
    .o_head    (head_c),
    .o_full    (full_c),
    .o_empty   (empty_c)
  );

  assign o_valid    = ~empty_c;
  assign o_data     = head_c[DW-1:0];
  assign o_bin      = head_c[BL +: LGWIDTH];
  assign o_last     = head_c[LB];
  assign o_aligned  = aligned_q;
  assign o_overflow = ovf_q;
  assign o_sync_err = serr_q;

endmodule

// File: tb/tb_fftsink.sv
// tb_fftsink: self-checking bench for fftsink with LGWIDTH=4, LGFIFO=2.
// Expected output words go into a scoreboard queue when driven and are
// checked when the DUT hands them over (o_valid && i_ready).
module tb_fftsink;

  localparam int unsigned OW  = 22;
  localparam int unsigned LGW = 4;
  localparam int unsigned LGF = 2;
  localparam int unsigned DW  = 2*OW;
  localparam int unsigned EW  = DW + LGW + 1;
  localparam int          NBIN = 1 << LGW;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_ce;
  logic [DW-1:0] i_result;
  logic          i_sync;
  logic          i_ready;
  logic          i_clr;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [LGW-1:0] o_bin;
  logic          o_last;
  logic          o_aligned;
  logic          o_overflow;
  logic          o_sync_err;

  fftsink #(.OWIDTH(OW), .LGWIDTH(LGW), .LGFIFO(LGF)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ce       (i_ce),
    .i_result   (i_result),
    .i_sync     (i_sync),
    .i_ready    (i_ready),
    .i_clr      (i_clr),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_bin      (o_bin),
    .o_last     (o_last),
    .o_aligned  (o_aligned),
    .o_overflow (o_overflow),
    .o_sync_err (o_sync_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] sb[$];

  typedef struct {
    logic          ce;
    logic          sync;
    logic [DW-1:0] d;
    logic          acc;
    int            bin;
    logic          valid_after;
    logic          aligned_after;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int bin, input logic [DW-1:0] d);
    logic l;
    l = (bin == NBIN - 1);
    return {l, LGW'(bin), d};
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom});
  endfunction

  // Output monitor: every accepted head word must match the scoreboard front.
  always @(negedge i_clk) begin
    if (i_reset_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got bin %0d data %0h, expected no word", o_bin, o_data);
      end else begin
        chk("out_word", 64'({o_last, o_bin, o_data}), 64'(sb.pop_front()));
      end
    end
  end

  task automatic step(input logic ce, input logic sync, input logic [DW-1:0] d,
                      input logic rdy, input logic clr);
    i_ce = ce; i_sync = sync; i_result = d; i_ready = rdy; i_clr = clr;
    @(posedge i_clk);
    #1;
  endtask

  // Drive n accepted words starting at first_bin; all are expected out.
  task automatic frame(input int first_bin, input int n, input logic sync_first, input logic rdy);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd();
      sb.push_back(mk(first_bin + i, d));
      step(1'b1, sync_first && (i == 0), d, rdy, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() != 0; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk({name, "_sb_left"}, 64'(sb.size()), 64'(0));
    chk({name, "_valid"}, 64'(o_valid), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] d;
    i_reset_n = 1'b0; i_ce = 1'b0; i_sync = 1'b0; i_result = '0;
    i_ready = 1'b0; i_clr = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_aligned", 64'(o_aligned), 64'(0));
    chk("rst_ovf", 64'(o_overflow), 64'(0));
    chk("rst_serr", 64'(o_sync_err), 64'(0));
    i_reset_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Align: 5 unsynced words are discarded, then a full frame from sync.
    for (int i = 0; i < 21; i++) begin
      tbl[i].ce = 1'b1;
      tbl[i].sync = (i == 5);
      tbl[i].d = (i < 5) ? rnd() : DW'(i - 4);
      tbl[i].acc = (i >= 5);
      tbl[i].bin = (i >= 5) ? i - 5 : 0;
      tbl[i].valid_after = (i >= 5);
      tbl[i].aligned_after = (i >= 5);
    end
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].acc) sb.push_back(mk(tbl[i].bin, tbl[i].d));
      step(tbl[i].ce, tbl[i].sync, tbl[i].d, 1'b1, 1'b0);
      chk("align_valid", 64'(o_valid), 64'(tbl[i].valid_after));
      chk("align_aligned", 64'(o_aligned), 64'(tbl[i].aligned_after));
    end
    drain("align");
    chk("align_ovf", 64'(o_overflow), 64'(0));
    chk("align_serr", 64'(o_sync_err), 64'(0));

    // Backpressure overflow: only bins 0-3 fit, the rest of the frame is lost.
    for (int i = 0; i < NBIN; i++) begin
      d = rnd();
      if (i < 4) sb.push_back(mk(i, d));
      step(1'b1, i == 0, d, 1'b0, 1'b0);
      if (i == 3) chk("ovf_not_yet", 64'(o_overflow), 64'(0));
      if (i == 4) begin
        chk("ovf_set", 64'(o_overflow), 64'(1));
        chk("ovf_drop_state", 64'(o_aligned), 64'(0));
      end
    end
    chk("ovf_held", 64'(sb.size()), 64'(4));
    chk("ovf_held_valid", 64'(o_valid), 64'(1));
    drain("ovf_partial");
    frame(0, NBIN, 1'b1, 1'b1);
    chk("ovf_realigned", 64'(o_aligned), 64'(1));
    drain("ovf_next");
    chk("ovf_sticky", 64'(o_overflow), 64'(1));
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("ovf_clr", 64'(o_overflow), 64'(0));

    // Sync error: expected sync at bin 0 is clean, sync at bin 7 flags and realigns.
    frame(0, 7, 1'b1, 1'b1);
    chk("serr_clean_sync", 64'(o_sync_err), 64'(0));
    d = rnd();
    sb.push_back(mk(0, d));
    step(1'b1, 1'b1, d, 1'b1, 1'b0);
    chk("serr_set", 64'(o_sync_err), 64'(1));
    chk("serr_aligned", 64'(o_aligned), 64'(1));
    frame(1, NBIN - 1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("serr_clr", 64'(o_sync_err), 64'(0));
    frame(0, 2, 1'b1, 1'b1);
    d = rnd();
    sb.push_back(mk(0, d));
    step(1'b1, 1'b1, d, 1'b1, 1'b1);
    chk("serr_set_wins", 64'(o_sync_err), 64'(1));
    frame(1, NBIN - 1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("serr_clr2", 64'(o_sync_err), 64'(0));
    drain("serr");

    // Gapped i_ce; a stray sync on idle cycles must be ignored.
    for (int i = 0; i < NBIN; i++) begin
      d = rnd();
      sb.push_back(mk(i, d));
      step(1'b1, i == 0, d, 1'b1, 1'b0);
      step(1'b0, 1'b1, rnd(), 1'b1, 1'b0);
    end
    chk("gap_serr", 64'(o_sync_err), 64'(0));
    drain("gap");

    // Full FIFO with a concurrent pop: the pop does not make room this cycle.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    frame(0, 4, 1'b1, 1'b0);
    chk("fullpop_ovf_before", 64'(o_overflow), 64'(0));
    step(1'b1, 1'b0, rnd(), 1'b1, 1'b0);
    chk("fullpop_ovf", 64'(o_overflow), 64'(1));
    chk("fullpop_drop", 64'(o_aligned), 64'(0));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("fullpop_count", 64'(sb.size()), 64'(3));
    chk("fullpop_valid", 64'(o_valid), 64'(1));
    drain("fullpop");

    // Async reset mid-frame with bins 7 and 8 queued.
    frame(0, 8, 1'b1, 1'b1);
    frame(8, 1, 1'b0, 1'b0);
    chk("rstmid_queued", 64'(sb.size()), 64'(2));
    chk("rstmid_ovf_pre", 64'(o_overflow), 64'(1));
    #2;
    i_reset_n = 1'b0;
    i_ce = 1'b0;
    #1;
    chk("rstmid_valid", 64'(o_valid), 64'(0));
    chk("rstmid_aligned", 64'(o_aligned), 64'(0));
    chk("rstmid_ovf", 64'(o_overflow), 64'(0));
    chk("rstmid_serr", 64'(o_sync_err), 64'(0));
    sb.delete();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, rnd(), 1'b1, 1'b0);
      chk("post_rst_valid", 64'(o_valid), 64'(0));
      chk("post_rst_aligned", 64'(o_aligned), 64'(0));
    end
    d = rnd();
    sb.push_back(mk(0, d));
    step(1'b1, 1'b1, d, 1'b1, 1'b0);
    chk("post_rst_sync_aligned", 64'(o_aligned), 64'(1));
    chk("post_rst_sync_valid", 64'(o_valid), 64'(1));
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
